// File: rtl/spu_stream_adapter.sv
// -----------------------------------------------------------------------------
// spu_stream_adapter
//
// Purpose:
//   Lets a fixed-latency, cke-stalled SPU pipeline (LATENCY stages) sit between
//   two valid/ready streams. Each accepted input beat is launched into the
//   external pipeline together with a 1-bit tag that travels down a LATENCY-deep
//   shift register. When a tag reaches the tail, the pipeline's result is
//   written into a small result FIFO. Admission is credit based: a beat is only
//   accepted if a FIFO slot is already reserved for it, so the result FIFO can
//   never overflow and the attached pipeline never has to stall because of
//   downstream backpressure.
//
// Parameters:
//   LATENCY     pipeline depth in cycles (>= 1)
//   DATA_BITS   width of every data path
//   FIFO_DEPTH  result FIFO entries (>= LATENCY+1; LATENCY+2 for full rate)
//
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous, active-low reset
//   cke          global clock enable; 0 freezes the whole block
//   s_data       input beat
//   s_valid      input beat valid
//   s_ready      input accept (depends on registered state and cke only)
//   pipe_cke     clock enable forwarded to the attached pipeline
//   pipe_s_data  data launched into the attached pipeline (= s_data)
//   pipe_m_data  result returning from the attached pipeline
//   m_data       FIFO head
//   m_valid      FIFO non-empty (and cke)
//   m_ready      downstream accept
//   stat_stall_count  (only with SPU_STREAM_ADAPTER_STATUS_EN) saturating count
//                     of cycles where a valid output was held off by m_ready
//
// Build option:
//   `define SPU_STREAM_ADAPTER_STATUS_EN to add the stat_stall_count output.
// -----------------------------------------------------------------------------
module spu_stream_adapter #(
    parameter int LATENCY    = 1,
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cke,
    input  logic [DATA_BITS-1:0] s_data,
    input  logic                 s_valid,
    output logic                 s_ready,
    output logic                 pipe_cke,
    output logic [DATA_BITS-1:0] pipe_s_data,
    input  logic [DATA_BITS-1:0] pipe_m_data,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready
`ifdef SPU_STREAM_ADAPTER_STATUS_EN
    ,
    output logic [31:0]          stat_stall_count
`endif
);

    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    // Parameter sanity checks at elaboration time.
    generate
        if (LATENCY < 1) begin : g_bad_latency
            $error("spu_stream_adapter: LATENCY must be >= 1");
        end
        if (FIFO_DEPTH < LATENCY + 1) begin : g_bad_depth
            $error("spu_stream_adapter: FIFO_DEPTH must be >= LATENCY+1");
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [OCC_W-1:0]     occ_q,    occ_d;     // in-flight tags + FIFO entries
    logic [LATENCY-1:0]   tag_q,    tag_d;     // 1 = stage carries a real beat
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]     cnt_q,    cnt_d;     // FIFO entries
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];

    logic accept;
    logic pop;
    logic fifo_wr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        // Explicit wrap so FIFO_DEPTH need not be a power of two.
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // ------------------------------------------------------------------
    // Handshakes and pipeline launch
    // ------------------------------------------------------------------
    // reset is folded in so that s_ready and pipe_cke are low while reset is
    // held, regardless of cke.
    assign s_ready     = cke && reset && (occ_q < OCC_W'(FIFO_DEPTH));
    assign m_valid     = cke && (cnt_q != '0);
    assign pipe_cke    = cke && reset;
    assign pipe_s_data = s_data;
    assign m_data      = mem_q[rd_ptr_q];

    assign accept  = s_valid && s_ready;
    assign pop     = m_valid && m_ready;
    assign fifo_wr = cke && tag_q[LATENCY-1];

    // Tag shift register: bit 0 takes this cycle's accept, the rest shift.
    assign tag_d[0] = accept;
    generate
        for (genvar gi = 1; gi < LATENCY; gi++) begin : g_tag
            assign tag_d[gi] = tag_q[gi-1];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        occ_d    = occ_q;
        cnt_d    = cnt_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;

        // A credit is taken on accept and only returned on pop, so occ_q is
        // always an upper bound on what the FIFO will ever have to hold.
        case ({accept, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase

        case ({fifo_wr, pop})
            2'b10:   cnt_d = cnt_q + OCC_W'(1);
            2'b01:   cnt_d = cnt_q - OCC_W'(1);
            default: cnt_d = cnt_q;
        endcase

        if (fifo_wr) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            occ_q    <= '0;
            tag_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (cke) begin
            occ_q    <= occ_d;
            tag_q    <= tag_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage is cleared on reset so m_data reads 0 rather than X afterwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (fifo_wr) begin
            mem_q[wr_ptr_q] <= pipe_m_data;
        end
    end

`ifdef SPU_STREAM_ADAPTER_STATUS_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (cke && m_valid && !m_ready && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stat_stall_count = stall_q;
`endif

endmodule

// File: tb/tb_spu_stream_adapter.sv
// -----------------------------------------------------------------------------
// tb_spu_stream_adapter
//
// Directed bench for spu_stream_adapter. Two instances with LATENCY=3 and
// DATA_BITS=8: "dut" with FIFO_DEPTH=5 and "dut4" with FIFO_DEPTH=4. Each has a
// 3-stage register chain clocked by its pipe_cke standing in for the SPU
// pipeline. A negedge monitor on "dut" keeps an in-order scoreboard of accepted
// beats and checks every pop against it.
// -----------------------------------------------------------------------------
module tb_spu_stream_adapter;

    localparam int LAT = 3;
    localparam int DW  = 8;

    logic          clk;
    logic          reset;
    logic          cke;

    // dut: FIFO_DEPTH = 5
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_ready;
    logic          pipe_cke;
    logic [DW-1:0] pipe_s_data;
    logic [DW-1:0] pipe_m_data;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;

    // dut4: FIFO_DEPTH = 4
    logic [DW-1:0] s_data2;
    logic          s_valid2;
    logic          s_ready2;
    logic          pipe_cke2;
    logic [DW-1:0] pipe_s_data2;
    logic [DW-1:0] pipe_m_data2;
    logic [DW-1:0] m_data2;
    logic          m_valid2;
    logic          m_ready2;

`ifdef SPU_STREAM_ADAPTER_STATUS_EN
    logic [31:0]   stat_stall_count;
    logic [31:0]   stat_stall_count2;
`endif

    int nvec = 0;
    int nerr = 0;
    int npop = 0;

    logic [DW-1:0] exp_q [$];
    logic          held_valid = 1'b0;
    logic [DW-1:0] held_data  = '0;

    spu_stream_adapter #(.LATENCY(LAT), .DATA_BITS(DW), .FIFO_DEPTH(5)) dut (
        .clk         (clk),
        .reset       (reset),
        .cke         (cke),
        .s_data      (s_data),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .pipe_cke    (pipe_cke),
        .pipe_s_data (pipe_s_data),
        .pipe_m_data (pipe_m_data),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready)
`ifdef SPU_STREAM_ADAPTER_STATUS_EN
        ,
        .stat_stall_count (stat_stall_count)
`endif
    );

    spu_stream_adapter #(.LATENCY(LAT), .DATA_BITS(DW), .FIFO_DEPTH(4)) dut4 (
        .clk         (clk),
        .reset       (reset),
        .cke         (cke),
        .s_data      (s_data2),
        .s_valid     (s_valid2),
        .s_ready     (s_ready2),
        .pipe_cke    (pipe_cke2),
        .pipe_s_data (pipe_s_data2),
        .pipe_m_data (pipe_m_data2),
        .m_data      (m_data2),
        .m_valid     (m_valid2),
        .m_ready     (m_ready2)
`ifdef SPU_STREAM_ADAPTER_STATUS_EN
        ,
        .stat_stall_count (stat_stall_count2)
`endif
    );

    // Stand-in SPU pipelines: LAT-stage register chains gated by pipe_cke.
    logic [DW-1:0] stg0_q, stg1_q, stg2_q;
    logic [DW-1:0] stg0b_q, stg1b_q, stg2b_q;

    always @(posedge clk) begin
        if (pipe_cke) begin
            stg0_q <= pipe_s_data;
            stg1_q <= stg0_q;
            stg2_q <= stg1_q;
        end
        if (pipe_cke2) begin
            stg0b_q <= pipe_s_data2;
            stg1b_q <= stg0b_q;
            stg2b_q <= stg1b_q;
        end
    end
    assign pipe_m_data  = stg2_q;
    assign pipe_m_data2 = stg2b_q;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Move to 1 time unit after the next rising edge (where inputs are driven).
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard / protocol monitor for "dut", sampled on the falling edge.
    always @(negedge clk) begin
        check("pipe_cke", {31'd0, pipe_cke}, {31'd0, cke && reset});
        check("pipe_s_data", {24'd0, pipe_s_data}, {24'd0, s_data});
        if (!reset || !cke) begin
            check("idle_s_ready", {31'd0, s_ready}, 32'd0);
            check("idle_m_valid", {31'd0, m_valid}, 32'd0);
        end
        if (!reset) begin
            held_valid <= 1'b0;
        end else begin
            if (held_valid && cke) begin
                check("hold_valid", {31'd0, m_valid}, 32'd1);
                check("hold_data", {24'd0, m_data}, {24'd0, held_data});
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check("pop_nonempty", 32'd0, 32'd1);
                end else begin
                    check("order", {24'd0, m_data}, {24'd0, exp_q[0]});
                    void'(exp_q.pop_front());
                end
                npop <= npop + 1;
                held_valid <= 1'b0;
            end else if (m_valid) begin
                held_valid <= 1'b1;
                held_data  <= m_data;
            end
            if (s_valid && s_ready) begin
                exp_q.push_back(s_data);
            end
            check("occ_bound", {31'd0, (exp_q.size() <= 5)}, 32'd1);
        end
    end

    initial begin
        int nacc;
        int pop0;
        int d2;
        int e2;
        int acc2;

        reset    = 1'b0;
        cke      = 1'b1;
        s_valid  = 1'b0;
        s_data   = '0;
        m_ready  = 1'b1;
        s_valid2 = 1'b0;
        s_data2  = '0;
        m_ready2 = 1'b1;

        // ---------------- reset state ----------------
        repeat (3) next();
        #3;
        check("rst_s_ready", {31'd0, s_ready}, 32'd0);
        check("rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_pipe_cke", {31'd0, pipe_cke}, 32'd0);
        check("rst_m_data", {24'd0, m_data}, 32'd0);
        next();
        reset = 1'b1;
        #3;
        check("post_rst_s_ready", {31'd0, s_ready}, 32'd1);
        check("post_rst_m_valid", {31'd0, m_valid}, 32'd0);
        next();

        // ---------------- single beat: 4-cycle latency ----------------
        s_valid = 1'b1;
        s_data  = 8'h5A;
        #3;
        check("single_accept", {31'd0, s_ready}, 32'd1);
        next();
        s_valid = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            #3;
            check("single_not_yet", {31'd0, m_valid}, 32'd0);
            check("single_s_ready", {31'd0, s_ready}, 32'd1);
            next();
        end
        #3;
        check("single_m_valid", {31'd0, m_valid}, 32'd1);
        check("single_m_data", {24'd0, m_data}, 32'h5A);
        next();
        #3;
        check("single_drained", {31'd0, m_valid}, 32'd0);
        next();

        // ---------------- streaming 100 beats ----------------
        pop0 = npop;
        for (int i = 0; i < 100; i++) begin
            s_valid = 1'b1;
            s_data  = DW'(i);
            #3;
            check("stream_s_ready", {31'd0, s_ready}, 32'd1);
            next();
        end
        s_valid = 1'b0;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) next();
        check("stream_drained", exp_q.size(), 32'd0);
        check("stream_pops", npop - pop0, 32'd100);

        // ---------------- backpressure ----------------
        m_ready = 1'b0;
        nacc = 0;
        for (int c = 0; c < 12; c++) begin
            s_valid = 1'b1;
            s_data  = DW'(8'h80 + nacc);
            #3;
            if (s_ready) nacc++;
            next();
        end
        #3;
        check("bp_accepts", nacc, 32'd5);
        check("bp_s_ready", {31'd0, s_ready}, 32'd0);
        check("bp_m_valid", {31'd0, m_valid}, 32'd1);
        check("bp_m_data", {24'd0, m_data}, 32'h80);
        next();
        pop0 = npop;
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) next();
        check("bp_drained", exp_q.size(), 32'd0);
        check("bp_pops", npop - pop0, 32'd5);

        // ---------------- cke gaps: 1,0,0,1 ----------------
        pop0 = npop;
        nacc = 0;
        for (int c = 0; c < 40; c++) begin
            cke     = ((c % 4) == 0) || ((c % 4) == 3);
            m_ready = (c % 3) != 0;
            s_valid = 1'b1;
            s_data  = DW'(8'hA0 + nacc);
            #3;
            if (s_ready) nacc++;
            next();
        end
        cke     = 1'b1;
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) next();
        check("gap_drained", exp_q.size(), 32'd0);
        check("gap_pops", npop - pop0, nacc);
        check("gap_some_accepts", {31'd0, (nacc >= 10)}, 32'd1);

        // ---------------- reset mid-flight ----------------
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1;
            s_data  = DW'(8'hC0 + i);
            #3;
            check("mid_accept", {31'd0, s_ready}, 32'd1);
            next();
        end
        s_valid = 1'b0;
        #3;
        check("mid_buffered", {31'd0, m_valid}, 32'd1);
        check("mid_head", {24'd0, m_data}, 32'hC0);
        exp_q.delete();
        reset = 1'b0;
        #1;
        check("mid_rst_m_valid", {31'd0, m_valid}, 32'd0);
        check("mid_rst_s_ready", {31'd0, s_ready}, 32'd0);
        check("mid_rst_pipe_cke", {31'd0, pipe_cke}, 32'd0);
        next();
        #3;
        check("mid_rst_m_valid2", {31'd0, m_valid}, 32'd0);
        check("mid_rst_s_ready2", {31'd0, s_ready}, 32'd0);
        next();
        reset   = 1'b1;
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'hD0;
        #3;
        check("mid_post_accept", {31'd0, s_ready}, 32'd1);
        next();
        s_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            #3;
            if (m_valid) break;
            next();
        end
        check("mid_post_valid", {31'd0, m_valid}, 32'd1);
        check("mid_post_data", {24'd0, m_data}, 32'hD0);
        next();
        #3;
        check("mid_post_empty", {31'd0, m_valid}, 32'd0);
        next();

        // ---------------- FIFO_DEPTH = LATENCY+1 throughput ----------------
        d2 = 0;
        e2 = 0;
        acc2 = 0;
        m_ready2 = 1'b1;
        for (int c = 0; c < 50; c++) begin
            s_valid2 = 1'b1;
            s_data2  = DW'(d2);
            #3;
            if (s_ready2) begin
                d2++;
                if (c >= 10) acc2++;
            end
            if (m_valid2) begin
                check("d4_order", {24'd0, m_data2}, {24'd0, DW'(e2)});
                e2++;
            end
            next();
        end
        s_valid2 = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #3;
            if (m_valid2) begin
                check("d4_order", {24'd0, m_data2}, {24'd0, DW'(e2)});
                e2++;
            end
            next();
        end
        check("d4_rate_40cyc", acc2, 32'd32);
        check("d4_all_out", e2, d2);

`ifdef SPU_STREAM_ADAPTER_STATUS_EN
        // ---------------- stall counter ----------------
        m_ready2 = 1'b0;
        s_valid2 = 1'b1;
        s_data2  = 8'h77;
        #3;
        check("stat_accept", {31'd0, s_ready2}, 32'd1);
        next();
        s_valid2 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            #3;
            if (m_valid2) break;
            next();
        end
        check("stat_valid", {31'd0, m_valid2}, 32'd1);
        repeat (7) next();
        m_ready2 = 1'b1;
        #3;
        check("stat_count", stat_stall_count2, 32'd7);
        check("stat_data", {24'd0, m_data2}, 32'h77);
        next();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
